// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: owns PC, drives ROM address, captures the ROM word into IR
module instr_fetch #(
    parameter int         ROM_LAT  = 1,
    parameter logic [6:0] RESET_PC = 7'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Fetch,
    input  logic        LoadPC,
    input  logic [6:0]  PCIn,
    input  logic [15:0] RomQ,
    output logic [6:0]  Addr,
    output logic [6:0]  PC,
    output logic [15:0] IR,
    output logic        IRValid,
    output logic        Busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Legal latencies are 1 and 2, so one counter bit covers the extra wait.
    localparam logic CNT_INIT = 1'(ROM_LAT - 1);

    state_t      state_q, state_n;
    logic [6:0]  pc_q, pc_n;
    logic [15:0] ir_q, ir_n;
    logic        irv_q, irv_n;
    logic        busy_q, busy_n;
    logic        cnt_q, cnt_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            irv_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            ir_q    <= ir_n;
            irv_q   <= irv_n;
            busy_q  <= busy_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        ir_n    = ir_q;
        irv_n   = 1'b0;
        busy_n  = busy_q;
        cnt_n   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // A jump wins over a fetch issued in the same cycle.
                if (LoadPC) begin
                    pc_n = PCIn;
                end else if (Fetch) begin
                    state_n = S_WAIT;
                    busy_n  = 1'b1;
                    cnt_n   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 1'b0) begin
                    cnt_n = cnt_q - 1'b1;
                end else begin
                    ir_n    = RomQ;
                    irv_n   = 1'b1;
                    pc_n    = pc_q + 7'd1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Addr comes straight from the PC register, so it is glitch-free and stable during a read.
    assign Addr    = pc_q;
    assign PC      = pc_q;
    assign IR      = ir_q;
    assign IRValid = irv_q;
    assign Busy    = busy_q;

endmodule
